axi_uart_fifo: RTL
==================

Name: axi_uart_fifo

Overview:
Parametrised successor to the single-register AXI-lite UART. It adds TX and RX FIFOs, a runtime-programmable baud divisor, sticky error flags and maskable interrupt sources. It sits on the CPU's AXI-lite peripheral bus and drives and receives the board serial line, 8N1 framing, LSB first.

Parameters:
ADDR_WIDTH, 4, AXI-lite address width; registers are decoded from addr[3:2]
FIFO_DEPTH, 16, entries per FIFO; power of two, at least 2
BAUD_DIV_RST, 868, reset value of the divisor; bit period is BAUD_DIV+1 clocks
DIV_WIDTH, 16, width of the divisor register

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset, sampled on the rising edge of clk
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes; only wstrb[0] and wstrb[1] are honoured
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response, always 2'b00
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response, always 2'b00
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
tx  out  1  serial output, idle high
rx  in  1  serial input, asynchronous
interrupt  out  1  level interrupt, active high

Behaviour:
- Register map (addr[3:2]):
  - 0 TXDATA (WO): a write pushes wdata[7:0] into the TX FIFO.
  - 1 RXDATA (RO): rdata[7:0] is the RX FIFO head; bit 8 is 1 if the FIFO was empty. A read pops the FIFO.
  - 2 STATUS: bit0 rx_not_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 overrun, bit5 frame_err, bit6 tx_busy. Writing 1 to bit4 or bit5 clears that flag; all other bits are read-only.
  - 3 CTRL: [DIV_WIDTH-1:0] BAUD_DIV; [DIV_WIDTH+2:DIV_WIDTH] enables for RXIE, TXIE, ERRIE.
- Reset values:
  - Outputs: tx=1, interrupt=0, all ready/valid=0, rdata=0, bresp=rresp=0.
  - State: FIFOs empty, flags 0, BAUD_DIV=BAUD_DIV_RST, IE=0.
  - Reset mid-frame aborts the frame immediately; tx returns high the following cycle.
- AXI write path:
  - Accepted only when awvalid and wvalid are both high and bvalid is 0.
  - awready and wready pulse high together for exactly 1 cycle; the register updates in that same cycle.
  - bvalid rises the next cycle and holds until bready.
  - Only one write is outstanding at a time.
  - A write with wstrb[0]=0 does not update TXDATA, STATUS, or CTRL[7:0].
- AXI read path:
  - Accepted when arvalid is high and rvalid is 0.
  - arready pulses for 1 cycle; rdata is registered and rvalid rises the next cycle, holding until rready.
  - The RXDATA pop happens at acceptance, so exactly one pop per read.
  - An empty RXDATA read returns 32'h100 and does not pop.
  - Writes to unmapped or read-only fields are ignored and still get OKAY.
- TX FIFO full: the write is dropped and the response is still OKAY; software polls tx_full.
- Baud generator:
  - Counter reloads at BAUD_DIV. A new divisor takes effect at the next frame boundary (TX and RX both idle).
  - BAUD_DIV=0 is treated as 1.
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - Leaves IDLE the cycle after the FIFO is non-empty and pops the FIFO at that transition.
  - Each state lasts BAUD_DIV+1 clocks.
  - Back-to-back bytes have no idle gap.
  - tx_busy = FSM not IDLE.
- RX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - rx passes through a 2-flop synchroniser.
  - A falling edge in IDLE starts a half-bit wait ((BAUD_DIV+1)/2 clocks). If rx is then high, the frame is a glitch and the FSM returns to IDLE.
  - Bits are sampled at mid-bit.
  - Stop bit 0: set frame_err and discard the byte.
  - Valid byte with RX FIFO full: set overrun and discard the byte (the FIFO contents are preserved).
  - A push and a pop in the same cycle on a full or empty FIFO are both honoured (count unchanged for a full FIFO; an empty FIFO gets no pop).
- interrupt is registered: (RXIE & rx_not_empty) | (TXIE & tx_empty & ~tx_busy) | (ERRIE & (overrun | frame_err)).

Test Plan:
1. CTRL=15 (16 clk/bit); write TXDATA 0xD4 -> tx low for 16 clk, then bits 0,0,1,0,1,0,1,1 at 16 clk each, stop high; tx_busy=0 after 160 clk; bvalid one cycle after the handshake; bresp=0.
2. Write 0xA1, 0xB2, 0xC3, 0xD4 back-to-back -> 4 contiguous frames with no gap; STATUS tx_empty=1 after 640 clk; with TXIE=1, interrupt rises then.
3. Drive an rx frame for 0x5A at 16 clk/bit -> STATUS bit0=1; RXDATA read returns 0x05A; a second RXDATA read returns 0x100.
4. Send FIFO_DEPTH+1 bytes with no reads -> rx_full=1, overrun=1; all 16 RXDATA reads return the first 16 bytes in order. Writing STATUS=0x10 clears overrun.
5. rx frame with stop bit 0 -> frame_err=1, FIFO unchanged, interrupt=1 with ERRIE=1. A 4-clk rx low glitch -> no byte, no flag.
6. Assert resetn=0 mid-TX frame -> tx=1 on the next cycle; after release, STATUS=0x04 and CTRL[15:0]=BAUD_DIV_RST.

Source files
------------

// File: rtl/axi_uart_fifo.sv
// AXI-lite UART with TX/RX byte FIFOs, runtime baud divisor, sticky error flags
// and a maskable level interrupt. Serial framing is 8N1, LSB first.

module axi_uart_fifo_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == (AW+1)'(0));
  assign full    = (count_q == (AW+1)'(DEPTH));
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    else         wr_ptr_d = wr_ptr_q;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    else         rd_ptr_d = rd_ptr_q;
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end
endmodule

module axi_uart_fifo #(
  parameter int ADDR_WIDTH   = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int BAUD_DIV_RST = 868,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  tx,
  input  logic                  rx,
  output logic                  interrupt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

  logic                 awready_q, awready_d, bvalid_q, bvalid_d;
  logic                 arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d, status_rd, ctrl_rd;
  logic                 wr_en, rd_en;
  logic [1:0]           wr_sel, rd_sel;
  logic [DIV_WIDTH-1:0] baud_div_q, baud_div_d, div_act_q, div_act_d;
  logic [DIV_WIDTH-1:0] div_sel, div_eff, half_m1;
  logic [DIV_WIDTH:0]   div_p1;
  logic [2:0]           ie_q, ie_d;
  logic                 overrun_q, overrun_d, frame_err_q, frame_err_d, irq_q, irq_d;
  logic                 ovr_set, ferr_set, both_idle, tx_busy;

  state_t               tx_state_q, tx_state_d;
  logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [7:0]           tx_shift_q, tx_shift_d, tx_dout;
  logic                 tx_q, tx_d, tx_push, tx_pop, tx_empty, tx_full;

  state_t               rx_state_q, rx_state_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [7:0]           rx_shift_q, rx_shift_d, rx_dout;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic                 rx_push, rx_pop, rx_empty, rx_full;
  logic                 unused_ok;

  assign unused_ok = ^{s_axi_wdata, s_axi_wstrb, s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign tx            = tx_q;
  assign interrupt     = irq_q;

  assign wr_en   = awready_q & s_axi_awvalid & s_axi_wvalid;
  assign rd_en   = arready_q & s_axi_arvalid;
  assign wr_sel  = s_axi_awaddr[3:2];
  assign rd_sel  = s_axi_araddr[3:2];
  assign tx_push = wr_en & (wr_sel == 2'd0) & s_axi_wstrb[0];
  assign rx_pop  = rd_en & (rd_sel == 2'd1) & ~rx_empty;
  assign tx_busy = (tx_state_q != S_IDLE);

  // The divisor in use only follows the programmed one while both directions are idle.
  assign both_idle = (tx_state_q == S_IDLE) && (rx_state_q == S_IDLE);
  assign div_sel   = both_idle ? baud_div_q : div_act_q;
  assign div_eff   = (div_sel == DIV_ZERO) ? DIV_ONE : div_sel;
  assign div_p1    = {1'b0, div_eff} + (DIV_WIDTH+1)'(1);
  assign half_m1   = DIV_WIDTH'((div_p1 >> 1) - (DIV_WIDTH+1)'(1));

  assign status_rd = {25'd0, tx_busy, frame_err_q, overrun_q, tx_full, tx_empty, rx_full, ~rx_empty};

  // Read-back image of the control register.
  always_comb begin
    ctrl_rd = 32'd0;
    ctrl_rd[DIV_WIDTH-1:0] = baud_div_q;
    ctrl_rd[DIV_WIDTH +: 3] = ie_q;
  end

  axi_uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .push(tx_push), .din(s_axi_wdata[7:0]),
    .pop(tx_pop), .dout(tx_dout), .empty(tx_empty), .full(tx_full)
  );

  axi_uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .push(rx_push), .din(rx_shift_d),
    .pop(rx_pop), .dout(rx_dout), .empty(rx_empty), .full(rx_full)
  );

  // AXI handshakes, register writes, read data and interrupt next-state.
  always_comb begin
    awready_d   = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
    arready_d   = s_axi_arvalid & ~rvalid_q & ~arready_q;
    baud_div_d  = baud_div_q;
    ie_d        = ie_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    rdata_d     = rdata_q;
    div_act_d   = div_sel;
    if (wr_en) bvalid_d = 1'b1;
    else if (s_axi_bready) bvalid_d = 1'b0;
    else bvalid_d = bvalid_q;
    if (wr_en && (wr_sel == 2'd3)) begin
      for (int i = 0; i < DIV_WIDTH; i++) begin
        if (i < 8) baud_div_d[i] = s_axi_wstrb[0] ? s_axi_wdata[i] : baud_div_q[i];
        else if (i < 16) baud_div_d[i] = s_axi_wstrb[1] ? s_axi_wdata[i] : baud_div_q[i];
        else baud_div_d[i] = s_axi_wdata[i];
      end
      ie_d = s_axi_wdata[DIV_WIDTH +: 3];
    end else begin
      baud_div_d = baud_div_q;
    end
    // A new error in the same cycle as its clear keeps the flag set.
    if (ovr_set) overrun_d = 1'b1;
    else if (wr_en && (wr_sel == 2'd2) && s_axi_wstrb[0] && s_axi_wdata[4]) overrun_d = 1'b0;
    else overrun_d = overrun_q;
    if (ferr_set) frame_err_d = 1'b1;
    else if (wr_en && (wr_sel == 2'd2) && s_axi_wstrb[0] && s_axi_wdata[5]) frame_err_d = 1'b0;
    else frame_err_d = frame_err_q;
    if (rd_en) begin
      rvalid_d = 1'b1;
      case (rd_sel)
        2'd1:    rdata_d = rx_empty ? 32'h0000_0100 : {24'd0, rx_dout};
        2'd2:    rdata_d = status_rd;
        2'd3:    rdata_d = ctrl_rd;
        default: rdata_d = 32'd0;
      endcase
    end else if (s_axi_rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
    irq_d = (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_empty & ~tx_busy) |
            (ie_q[2] & (overrun_q | frame_err_q));
  end

  // Transmit sequencer; a byte waiting at the end of a stop bit starts the next frame at once.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_shift_d = tx_dout; tx_cnt_d = div_eff; tx_state_d = S_START;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tx_cnt_q == DIV_ZERO) begin
          tx_state_d = S_DATA; tx_cnt_d = div_eff; tx_bit_d = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == DIV_ZERO) begin
          tx_cnt_d   = div_eff;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else tx_bit_d = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q != DIV_ZERO) begin
          tx_cnt_d = tx_cnt_q - DIV_ONE;
        end else if (!tx_empty) begin
          tx_pop = 1'b1; tx_shift_d = tx_dout; tx_cnt_d = div_eff; tx_state_d = S_START;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Receive sequencer: half-bit start qualification, then mid-bit sampling.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ovr_set    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = S_START; rx_cnt_d = half_m1;
        end else begin
          rx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (rx_cnt_q != DIV_ZERO) rx_cnt_d = rx_cnt_q - DIV_ONE;
        else if (rx_sync_q) rx_state_d = S_IDLE;
        else begin
          rx_state_d = S_DATA; rx_cnt_d = div_eff; rx_bit_d = 3'd0;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == DIV_ZERO) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = div_eff;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_q != DIV_ZERO) begin
          rx_cnt_d = rx_cnt_q - DIV_ONE;
        end else begin
          rx_state_d = S_IDLE;
          if (!rx_sync_q) ferr_set = 1'b1;
          else if (rx_full && !rx_pop) ovr_set = 1'b1;
          else rx_push = 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // All state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      awready_q   <= 1'b0;  bvalid_q <= 1'b0;
      arready_q   <= 1'b0;  rvalid_q <= 1'b0;
      rdata_q     <= 32'd0;
      baud_div_q  <= DIV_WIDTH'(BAUD_DIV_RST);
      div_act_q   <= DIV_WIDTH'(BAUD_DIV_RST);
      ie_q        <= 3'd0;
      overrun_q   <= 1'b0;  frame_err_q <= 1'b0;  irq_q <= 1'b0;
      tx_state_q  <= S_IDLE; tx_cnt_q <= DIV_ZERO; tx_bit_q <= 3'd0;
      tx_shift_q  <= 8'd0;  tx_q <= 1'b1;
      rx_state_q  <= S_IDLE; rx_cnt_q <= DIV_ZERO; rx_bit_q <= 3'd0;
      rx_shift_q  <= 8'd0;
      rx_meta_q   <= 1'b1;  rx_sync_q <= 1'b1;  rx_prev_q <= 1'b1;
    end else begin
      awready_q   <= awready_d;  bvalid_q <= bvalid_d;
      arready_q   <= arready_d;  rvalid_q <= rvalid_d;
      rdata_q     <= rdata_d;
      baud_div_q  <= baud_div_d;
      div_act_q   <= div_act_d;
      ie_q        <= ie_d;
      overrun_q   <= overrun_d;  frame_err_q <= frame_err_d;  irq_q <= irq_d;
      tx_state_q  <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d;
      tx_shift_q  <= tx_shift_d; tx_q <= tx_d;
      rx_state_q  <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_meta_q   <= rx;  rx_sync_q <= rx_meta_q;  rx_prev_q <= rx_sync_q;
    end
  end
endmodule
